// File: rtl/vip_frame_transmitter.sv
// Avalon-ST Video source: wraps a raw pixel stream into a VIP frame (optional control packet + video packet).
// Define VIP_TX_CTRL_PACKET_EN to emit a width/height/interlace control packet ahead of every video packet.
module vip_frame_transmitter #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int WIDTH            = 512,
  parameter int HEIGHT           = 288
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [15:0]                                 width_in,
  input  logic [15:0]                                 height_in,
  input  logic [3:0]                                  interlaced_in,
  input  logic                                        pix_valid,
  output logic                                        pix_ready,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] pix_data,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        busy,
  output logic                                        frame_done,
  output logic                                        start_err
);
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  // State names the next beat to load; the first packet header is loaded straight from IDLE.
`ifdef VIP_TX_CTRL_PACKET_EN
  typedef enum logic [1:0] {IDLE, CTRL_DATA, VID_HDR, VID_DATA} state_t;

  function automatic logic [BITS_PER_SYMBOL-1:0] sym(input logic [3:0] nib);
    sym      = '0;
    sym[3:0] = nib;
  endfunction
`else
  typedef enum logic [1:0] {IDLE, VID_DATA} state_t;
`endif

  state_t        state_q, state_d;
  logic [15:0]   width_q, width_d, height_q, height_d;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d, frame_done_q, frame_done_d, start_err_q, start_err_d;
  logic          vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic [DW-1:0] data_q, data_d;
`ifdef VIP_TX_CTRL_PACKET_EN
  logic [3:0]    il_q, il_d;
  logic [1:0]    cnt_q, cnt_d;
`else
  logic          unused_interlace;
  assign unused_interlace = ^interlaced_in;
`endif

  logic          can_load, pix_ready_c, at_end, load, ld_sop, ld_eop;
  logic [DW-1:0] ld_data;

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    x_d          = x_q;
    y_d          = y_q;
    last_d       = last_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start_err_d  = 1'b0;
    vld_d        = vld_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    data_d       = data_q;
`ifdef VIP_TX_CTRL_PACKET_EN
    il_d         = il_q;
    cnt_d        = cnt_q;
`endif
    load         = 1'b0;
    ld_sop       = 1'b0;
    ld_eop       = 1'b0;
    ld_data      = '0;
    can_load     = !vld_q || dout_ready;
    pix_ready_c  = (state_q == VID_DATA) && can_load && !last_q;
    at_end       = (x_q == width_q - 16'd1) && (y_q == height_q - 16'd1);

    if (vld_q && dout_ready) vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (width_in != 16'd0 && height_in != 16'd0) begin
            width_d  = width_in;
            height_d = height_in;
            x_d      = '0;
            y_d      = '0;
            last_d   = 1'b0;
            busy_d   = 1'b1;
            load     = 1'b1;
            ld_sop   = 1'b1;
`ifdef VIP_TX_CTRL_PACKET_EN
            il_d     = interlaced_in;
            cnt_d    = '0;
            ld_data  = {sym(4'h0), sym(4'h0), sym(4'hF)};
            state_d  = CTRL_DATA;
`else
            state_d  = VID_DATA;
`endif
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
`ifdef VIP_TX_CTRL_PACKET_EN
      CTRL_DATA: begin
        if (can_load) begin
          load  = 1'b1;
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0:    ld_data = {sym(width_q[7:4]), sym(width_q[11:8]), sym(width_q[15:12])};
            2'd1:    ld_data = {sym(height_q[11:8]), sym(height_q[15:12]), sym(width_q[3:0])};
            default: begin
              ld_data = {sym(il_q), sym(height_q[3:0]), sym(height_q[7:4])};
              ld_eop  = 1'b1;
              state_d = VID_HDR;
            end
          endcase
        end
      end
      VID_HDR: begin
        if (can_load) begin
          load    = 1'b1;
          ld_sop  = 1'b1;
          state_d = VID_DATA;
        end
      end
`endif
      VID_DATA: begin
        if (pix_ready_c && pix_valid) begin
          load    = 1'b1;
          ld_data = pix_data;
          ld_eop  = at_end;
          last_d  = at_end;
          if (x_q == width_q - 16'd1) begin
            x_d = '0;
            y_d = y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
        end else if (last_q && vld_q && dout_ready) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      vld_d  = 1'b1;
      sop_d  = ld_sop;
      eop_d  = ld_eop;
      data_d = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      width_q      <= 16'(WIDTH);
      height_q     <= 16'(HEIGHT);
      x_q          <= '0;
      y_q          <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
      vld_q        <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      data_q       <= '0;
`ifdef VIP_TX_CTRL_PACKET_EN
      il_q         <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      x_q          <= x_d;
      y_q          <= y_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
      vld_q        <= vld_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      data_q       <= data_d;
`ifdef VIP_TX_CTRL_PACKET_EN
      il_q         <= il_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign pix_ready  = pix_ready_c;
  assign dout_valid = vld_q;
  assign dout_sop   = sop_q;
  assign dout_eop   = eop_q;
  assign dout_data  = data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign start_err  = start_err_q;

endmodule

// File: tb/tb_vip_frame_transmitter.sv
// Self-checking bench for vip_frame_transmitter: directed frames plus randomized frames against a beat-list model.
`timescale 1ns/1ps
module tb_vip_frame_transmitter;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   width_in = '0;
  logic [15:0]   height_in = '0;
  logic [3:0]    interlaced_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] pix_data = '0;
  logic          dout_ready = 1'b0;
  logic          dout_valid, dout_sop, dout_eop;
  logic [DW-1:0] dout_data;
  logic          busy, frame_done, start_err;

  int n_vec = 0;
  int n_err = 0;

  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] pix_q[$];

  vip_frame_transmitter dut (
    .clk(clk), .rst(rst), .start(start), .width_in(width_in), .height_in(height_in),
    .interlaced_in(interlaced_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .dout_ready(dout_ready), .dout_valid(dout_valid),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_data(dout_data), .busy(busy),
    .frame_done(frame_done), .start_err(start_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // {s2,s1,s0} with one nibble in the low bits of each 8-bit symbol
  function automatic logic [DW-1:0] nib3(input int s2, input int s1, input int s0);
    return DW'(((s2 & 15) << 16) | ((s1 & 15) << 8) | (s0 & 15));
  endfunction

  task automatic build_model(input int w, input int h, input int il, input bit directed);
    exp_q.delete();
    pix_q.delete();
    for (int i = 0; i < w * h; i++) pix_q.push_back(directed ? DW'(i + 1) : DW'($urandom));
    if (directed) begin
`ifdef VIP_TX_CTRL_PACKET_EN
      exp_q.push_back({2'b10, 24'h00000F});
      exp_q.push_back({2'b00, 24'h000000});
      exp_q.push_back({2'b00, 24'h000004});
      exp_q.push_back({2'b01, 24'h000200});
`endif
      exp_q.push_back({2'b10, 24'h000000});
      for (int i = 1; i <= 8; i++) exp_q.push_back({1'b0, (i == 8), 24'(i)});
    end else begin
`ifdef VIP_TX_CTRL_PACKET_EN
      exp_q.push_back({2'b10, 24'h00000F});
      exp_q.push_back({2'b00, nib3(w >> 4, w >> 8, w >> 12)});
      exp_q.push_back({2'b00, nib3(h >> 8, h >> 12, w)});
      exp_q.push_back({2'b01, nib3(il, h, h >> 4)});
`endif
      exp_q.push_back({2'b10, 24'h000000});
      for (int i = 0; i < w * h; i++) exp_q.push_back({1'b0, (i == w * h - 1), pix_q[i]});
    end
  endtask

  task automatic drive(input int rmode, input int pmode, input int cyc);
    case (rmode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = (cyc % 2 == 0);
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
    case (pmode)
      0:       pix_valid = 1'b1;
      1:       pix_valid = (cyc % 3 != 2);
      default: pix_valid = ($urandom_range(0, 3) != 0);
    endcase
    pix_data = (pix_q.size() != 0) ? pix_q[0] : DW'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int w, input int h, input int il,
                           input int rmode, input int pmode, input bit directed, input bit mid_start);
    bit            done = 1'b0;
    bit            stall_prev = 1'b0;
    bit            pend = 1'b0;
    int            bubbles = 0;
    int            ncyc = 0;
    int            nbeats;
    logic [DW+1:0] saved = '0;
    logic [DW+1:0] e;
    logic [DW-1:0] pend_val = '0;
    build_model(w, h, il, directed);
    nbeats = exp_q.size();
    @(posedge clk); #1;
    start = 1'b1; width_in = 16'(w); height_in = 16'(h); interlaced_in = 4'(il);
    dout_ready = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; width_in = 16'($urandom); height_in = 16'($urandom); interlaced_in = 4'($urandom);
    drive(rmode, pmode, 0);
    @(negedge clk);
    chk({nm, ":busy_after_start"}, busy, 1);
    chk({nm, ":valid_after_start"}, dout_valid, 1);
    for (int cyc = 1; cyc < 4000 && !done; cyc++) begin
      ncyc++;
      if (stall_prev) chk({nm, ":stall_hold"}, {dout_sop, dout_eop, dout_data}, saved);
      if (dout_valid && !dout_ready) chk({nm, ":pix_ready_in_stall"}, pix_ready, 0);
      if (pend) begin
        chk({nm, ":pix_latency"}, {dout_valid, dout_data}, {1'b1, pend_val});
        pend = 1'b0;
      end
      if (!dout_valid) bubbles++;
      if (dout_valid && dout_ready) begin
        chk({nm, ":beat_expected"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk({nm, ":beat"}, {dout_sop, dout_eop, dout_data}, e);
          if (exp_q.size() == 0) done = 1'b1;
        end
      end
      if (pix_valid && pix_ready) begin
        chk({nm, ":pixel_expected"}, pix_q.size() != 0, 1);
        if (pix_q.size() != 0) begin
          pend_val = pix_q.pop_front();
          pend = 1'b1;
        end
      end
      stall_prev = dout_valid && !dout_ready;
      saved = {dout_sop, dout_eop, dout_data};
      @(posedge clk);
      if (!done) begin
        #1;
        drive(rmode, pmode, cyc);
        if (mid_start && cyc == 3) begin
          start = 1'b1; width_in = 16'd3; height_in = 16'd3; interlaced_in = 4'hA;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    chk({nm, ":completed"}, done, 1);
    if (!done) begin
      do_reset();
    end else begin
      @(negedge clk);
      chk({nm, ":frame_done_pulse"}, frame_done, 1);
      chk({nm, ":busy_fall"}, busy, 0);
      chk({nm, ":valid_clear"}, dout_valid, 0);
      if (rmode == 0 && pmode == 0) begin
        chk({nm, ":no_bubbles"}, bubbles, 0);
        chk({nm, ":beat_count"}, ncyc, nbeats);
      end
      @(negedge clk);
      chk({nm, ":frame_done_single"}, frame_done, 0);
    end
    pix_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic start_error(input string nm, input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1; width_in = 16'(w); height_in = 16'(h);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({nm, ":start_err"}, start_err, 1);
    chk({nm, ":no_valid"}, dout_valid, 0);
    chk({nm, ":not_busy"}, busy, 0);
    @(negedge clk);
    chk({nm, ":start_err_single"}, start_err, 0);
    chk({nm, ":still_idle"}, {busy, dout_valid}, 0);
  endtask

  initial begin
    #1;
    chk("reset:outputs", {dout_valid, dout_sop, dout_eop, dout_data, pix_ready, busy, frame_done, start_err}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle:valid", dout_valid, 0);

    run_frame("w4h2_full", 4, 2, 0, 0, 0, 1'b1, 1'b0);
    run_frame("w4h2_ready_toggle", 4, 2, 0, 1, 0, 1'b1, 1'b0);
    run_frame("w4h2_pix_gaps", 4, 2, 0, 0, 1, 1'b1, 1'b0);
    run_frame("w2h1", 2, 1, 0, 0, 0, 1'b0, 1'b0);
    run_frame("start_while_busy", 5, 3, 9, 2, 2, 1'b0, 1'b1);

    start_error("zero_width", 0, 5);
    start_error("zero_height", 7, 0);

    // reset in the middle of a frame
    build_model(4, 2, 0, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; width_in = 16'd4; height_in = 16'd2; dout_ready = 1'b1; pix_valid = 1'b1; pix_data = 24'h55AA33;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset:outputs", {dout_valid, dout_sop, dout_eop, dout_data, pix_ready, busy, frame_done, start_err}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("after_reset:idle", {dout_valid, busy, pix_ready}, 0);
    pix_valid = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("rand%0d", k), $urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 15),
                $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
